// File: rtl/frame_serializer_pkg.sv
// Shared types and helpers for the frame serializer: FSM state encoding and beat-count math.
package frame_serializer_pkg;

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    // Beats per frame, with or without the PAD zero words on each side.
    function automatic int unsigned num_beats(input int unsigned frame_len,
                                              input int unsigned pad,
                                              input int unsigned lanes,
                                              input logic        pad_en);
        if (pad_en) begin
            return (frame_len + 2 * pad) / lanes;
        end
        return frame_len / lanes;
    endfunction

endpackage

// File: rtl/frame_serializer_fifo.sv
// Circular beat FIFO: pushes only when not full, pops only when not empty; storage is reset
// so the head entry reads as zero while empty after reset.
module beat_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         wen_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic                         full_o,
    input  logic                         ren_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign push = wen_i && !full_o;
    assign pop  = ren_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Captures a whole frame, optionally wraps it in PAD zero words, and streams it out as
// LANES-word beats through a small FIFO with a per-frame last marker.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned LANES     = 1,
    parameter int unsigned PAD       = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [FRAME_LEN*WORD_SIZE-1:0] data_i,
    input  logic                           pad_en_i,
    output logic                           valid_o,
    input  logic                           yumi_i,
    output logic [LANES*WORD_SIZE-1:0]     data_o,
    output logic                           last_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned BeatBits = LANES * WORD_SIZE;
    localparam int unsigned NbPad    = num_beats(FRAME_LEN, PAD, LANES, 1'b1);
    localparam int unsigned NbNoPad  = num_beats(FRAME_LEN, PAD, LANES, 1'b0);
    localparam int unsigned BeatW    = $clog2(NbPad + 1);
    localparam int unsigned NumSlots = 2 ** BeatW;
    localparam logic [BeatW-1:0] LastPad   = BeatW'(NbPad - 1);
    localparam logic [BeatW-1:0] LastNoPad = BeatW'(NbNoPad - 1);

    state_e                         state_q, state_d;
    logic [FRAME_LEN*WORD_SIZE-1:0] frame_q;
    logic                           pad_q;
    logic [BeatW-1:0]               beat_q, beat_d;
    logic                           capture;
    logic                           push;
    logic                           last_beat;

    logic [NumSlots-1:0][BeatBits-1:0] stream;
    logic [BeatBits-1:0]               beat_data;

    logic                fifo_full;
    logic                fifo_empty;
    logic [BeatBits:0]   fifo_rdata;

    // Stream laid out beat-indexed so the mux index is exactly beat_q; unused slots stay zero.
    always_comb begin
        stream = '0;
        if (pad_q) begin
            stream[PAD/LANES +: FRAME_LEN/LANES] = frame_q;
        end else begin
            stream[0 +: FRAME_LEN/LANES] = frame_q;
        end
    end

    assign beat_data = stream[beat_q];
    assign last_beat = (beat_q == (pad_q ? LastPad : LastNoPad));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ready_o = 1'b0;
        capture = 1'b0;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    capture = 1'b1;
                    beat_d  = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!fifo_full) begin
                    push = 1'b1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            beat_q  <= '0;
            frame_q <= '0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (capture) begin
                frame_q <= data_i;
                pad_q   <= pad_en_i;
            end
        end
    end

    beat_fifo #(
        .WIDTH (BeatBits + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wen_i   (push),
        .wdata_i ({last_beat, beat_data}),
        .full_o  (fifo_full),
        .ren_i   (yumi_i),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign valid_o = !fifo_empty;
    assign data_o  = fifo_rdata[BeatBits-1:0];
    assign last_o  = fifo_rdata[BeatBits];

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer with FRAME_LEN=8, LANES=2, PAD=2, DEPTH=4, WORD_SIZE=16.
module tb_frame_serializer;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned LANES     = 2;
    localparam int unsigned PAD       = 2;
    localparam int unsigned DEPTH     = 4;

    logic                           clk_i = 1'b0;
    logic                           reset_i;
    logic                           valid_i;
    logic                           ready_o;
    logic [FRAME_LEN*WORD_SIZE-1:0] data_i;
    logic                           pad_en_i;
    logic                           valid_o;
    logic                           yumi_i;
    logic [LANES*WORD_SIZE-1:0]     data_o;
    logic                           last_o;
    logic [2:0]                     count_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    frame_serializer #(
        .WORD_SIZE (WORD_SIZE),
        .FRAME_LEN (FRAME_LEN),
        .LANES     (LANES),
        .PAD       (PAD),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .pad_en_i (pad_en_i),
        .valid_o  (valid_o),
        .yumi_i   (yumi_i),
        .data_o   (data_o),
        .last_o   (last_o),
        .count_o  (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Record each popped beat mid-cycle, while outputs are settled.
    always @(negedge clk_i) begin
        if (!reset_i && valid_o && yumi_i) begin
            got_q.push_back({last_o, data_o});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_frame(input logic [15:0] base);
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            data_i[i*WORD_SIZE +: WORD_SIZE] = base + 16'(i);
        end
    endtask

    task automatic push_exp(input logic last, input logic [15:0] hi, input logic [15:0] lo);
        exp_q.push_back({last, hi, lo});
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && !(ready_o && !valid_o); i++) begin
            tick();
        end
        check({tag, "_drain"}, 64'(ready_o && !valid_o), 64'd1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset_i  = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        pad_en_i = 1'b0;
        yumi_i   = 1'b0;

        // 1. Reset, then yumi on an empty FIFO
        tick();
        tick();
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_last", 64'(last_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        reset_i = 1'b0;
        yumi_i  = 1'b1;
        tick();
        tick();
        check("empty_yumi_count", 64'(count_o), 64'd0);
        check("empty_yumi_valid", 64'(valid_o), 64'd0);

        // 2. No padding, free-running consumer
        got_q.delete();
        set_frame(16'h0001);
        pad_en_i = 1'b0;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        check("nopad_ready_low", 64'(ready_o), 64'd0);
        check("nopad_valid_t0", 64'(valid_o), 64'd0);
        tick();
        check("nopad_valid_t1", 64'(valid_o), 64'd1);
        check("nopad_first_data", 64'(data_o), 64'h0002_0001);
        wait_drain("nopad");
        push_exp(1'b0, 16'h0002, 16'h0001);
        push_exp(1'b0, 16'h0004, 16'h0003);
        push_exp(1'b0, 16'h0006, 16'h0005);
        push_exp(1'b1, 16'h0008, 16'h0007);
        compare_stream("nopad");

        // 3. Padding enabled
        set_frame(16'h0001);
        pad_en_i = 1'b1;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        wait_drain("pad");
        push_exp(1'b0, 16'h0000, 16'h0000);
        push_exp(1'b0, 16'h0002, 16'h0001);
        push_exp(1'b0, 16'h0004, 16'h0003);
        push_exp(1'b0, 16'h0006, 16'h0005);
        push_exp(1'b0, 16'h0008, 16'h0007);
        push_exp(1'b1, 16'h0000, 16'h0000);
        compare_stream("pad");

        // 4. Backpressure on a padded (6-beat) frame
        yumi_i   = 1'b0;
        set_frame(16'h0001);
        pad_en_i = 1'b1;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (8) tick();
        check("bp_count_full", 64'(count_o), 64'd4);
        check("bp_ready_low", 64'(ready_o), 64'd0);
        check("bp_valid", 64'(valid_o), 64'd1);
        check("bp_head_data", 64'(data_o), 64'h0000_0000);
        check("bp_head_last", 64'(last_o), 64'd0);
        yumi_i = 1'b1;
        wait_drain("bp");
        push_exp(1'b0, 16'h0000, 16'h0000);
        push_exp(1'b0, 16'h0002, 16'h0001);
        push_exp(1'b0, 16'h0004, 16'h0003);
        push_exp(1'b0, 16'h0006, 16'h0005);
        push_exp(1'b0, 16'h0008, 16'h0007);
        push_exp(1'b1, 16'h0000, 16'h0000);
        compare_stream("bp");

        // 5. Back-to-back: unpadded frame A, then padded frame B held on valid_i
        set_frame(16'h0001);
        pad_en_i = 1'b0;
        valid_i  = 1'b1;
        tick();
        set_frame(16'h0011);
        pad_en_i = 1'b1;
        repeat (3) tick();
        check("b2b_ready_send", 64'(ready_o), 64'd0);
        tick();
        check("b2b_ready_idle", 64'(ready_o), 64'd1);
        tick();
        check("b2b_accept_b", 64'(ready_o), 64'd0);
        valid_i = 1'b0;
        wait_drain("b2b");
        push_exp(1'b0, 16'h0002, 16'h0001);
        push_exp(1'b0, 16'h0004, 16'h0003);
        push_exp(1'b0, 16'h0006, 16'h0005);
        push_exp(1'b1, 16'h0008, 16'h0007);
        push_exp(1'b0, 16'h0000, 16'h0000);
        push_exp(1'b0, 16'h0012, 16'h0011);
        push_exp(1'b0, 16'h0014, 16'h0013);
        push_exp(1'b0, 16'h0016, 16'h0015);
        push_exp(1'b0, 16'h0018, 16'h0017);
        push_exp(1'b1, 16'h0000, 16'h0000);
        compare_stream("b2b");

        // 6. Reset after two beats are pushed, then a fresh frame
        yumi_i   = 1'b0;
        set_frame(16'h0001);
        pad_en_i = 1'b0;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        check("mid_count_pre", 64'(count_o), 64'd2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("mid_count", 64'(count_o), 64'd0);
        check("mid_valid", 64'(valid_o), 64'd0);
        check("mid_ready", 64'(ready_o), 64'd1);
        check("mid_data", 64'(data_o), 64'd0);
        got_q.delete();
        yumi_i = 1'b1;
        set_frame(16'h0011);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        wait_drain("mid");
        push_exp(1'b0, 16'h0012, 16'h0011);
        push_exp(1'b0, 16'h0014, 16'h0013);
        push_exp(1'b0, 16'h0016, 16'h0015);
        push_exp(1'b1, 16'h0018, 16'h0017);
        compare_stream("mid");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
